// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: sequences single or burst read/write requests onto a
// word-addressed memory with a combinational read port and a posedge write
// port. Write beats stream straight through to the memory. Each read beat
// takes one cycle to capture the memory word, then waits on the response
// channel until the consumer takes it.
module mem_burst_ctrl #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int LW = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // request channel
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_write,
  input  logic [AW-1:0] i_req_addr,
  input  logic [LW-1:0] i_req_len,
  // write beat channel
  input  logic          i_wdata_valid,
  output logic          o_wdata_ready,
  input  logic [DW-1:0] i_wdata,
  // read response channel
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [DW-1:0] o_rsp_data,
  // status
  output logic          o_done,
  output logic          o_busy,
  // memory port
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RSP  = 2'd2,
    S_WR   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic [AW-1:0] r_cur_addr;
  logic [LW-1:0] r_beats_left;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_data;
  logic          r_done;

  // Handshake events for the current cycle.
  logic          w_accept;
  logic          w_wr_beat;
  logic          w_rsp_take;
  logic          w_beat_done;
  logic          w_last_beat;

  // beats_left counts beats remaining after the current one, so zero marks
  // the final beat of the burst.
  assign w_last_beat = (r_beats_left == '0);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_state_next = i_req_write ? S_WR : S_RD;
        end
      end
      S_RD: begin
        // The memory read is combinational, so a single cycle is enough
        // to capture the word.
        w_state_next = S_RSP;
      end
      S_RSP: begin
        if (r_rsp_valid && i_rsp_ready) begin
          w_state_next = w_last_beat ? S_IDLE : S_RD;
        end
      end
      S_WR: begin
        if (i_wdata_valid && w_last_beat) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output and handshake decode from the current state.
  always_comb begin
    o_req_ready   = (r_state == S_IDLE);
    o_wdata_ready = (r_state == S_WR);
    o_busy        = (r_state != S_IDLE);
    w_accept      = (r_state == S_IDLE) && i_req_valid;
    w_wr_beat     = (r_state == S_WR) && i_wdata_valid;
    w_rsp_take    = (r_state == S_RSP) && r_rsp_valid && i_rsp_ready;
    w_beat_done   = w_wr_beat || w_rsp_take;
    // The memory commits the write on the same edge that consumes the beat.
    o_mem_we      = w_wr_beat;
  end

  // Burst address and beat counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cur_addr   <= '0;
      r_beats_left <= '0;
    end else if (w_accept) begin
      r_cur_addr   <= i_req_addr;
      r_beats_left <= i_req_len;
    end else if (w_beat_done && !w_last_beat) begin
      // Address arithmetic wraps naturally at 2**AW.
      r_cur_addr   <= r_cur_addr + AW'(1);
      r_beats_left <= r_beats_left - LW'(1);
    end
  end

  // Read response holding register; data stays put until it is taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else if (r_state == S_RD) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= i_mem_rdata;
    end else if (w_rsp_take) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Completion pulse, high in the first IDLE cycle after the final beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_beat_done && w_last_beat;
    end
  end

  assign o_mem_addr  = r_cur_addr;
  assign o_mem_wdata = i_wdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_done      = r_done;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: a 64K-word memory, a per-cycle reference model of
// the burst protocol with a shadow memory, and directed scenarios with
// literal expectations.
module tb_mem_burst_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_write = 1'b0;
  logic [15:0] i_req_addr = '0;
  logic [3:0]  i_req_len = '0;
  logic        i_wdata_valid = 1'b0;
  logic        o_wdata_ready;
  logic [15:0] i_wdata = '0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [15:0] o_rsp_data;
  logic        o_done;
  logic        o_busy;
  logic        o_mem_we;
  logic [15:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_burst_ctrl #(.AW(16), .DW(16), .LW(4)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_write  (i_req_write),
    .i_req_addr   (i_req_addr),
    .i_req_len    (i_req_len),
    .i_wdata_valid(i_wdata_valid),
    .o_wdata_ready(o_wdata_ready),
    .i_wdata      (i_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_data   (o_rsp_data),
    .o_done       (o_done),
    .o_busy       (o_busy),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // The memory itself: combinational read, write on posedge.
  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end
  end
  assign i_mem_rdata = mem[o_mem_addr];
  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for handshake at %0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  // m_mode: 0 idle, 1 write burst, 2 read burst. m_rem counts beats still
  // to transfer including the current one.
  int          m_mode = 0;
  logic [15:0] m_addr = '0;
  int          m_rem = 0;
  bit          m_rsp_valid = 1'b0;
  bit          m_done = 1'b0;
  int          done_cnt = 0;
  int          we_cnt = 0;

  function automatic void m_finish_beat();
    if (m_rem == 1) begin
      m_mode = 0;
      m_done = 1'b1;
    end else begin
      m_addr = m_addr + 16'd1;
      m_rem  = m_rem - 1;
    end
  endfunction

  always @(negedge i_clk) begin
    if (i_rst) begin
      chk("rst_busy", 32'(o_busy), 32'(0));
      chk("rst_rsp_valid", 32'(o_rsp_valid), 32'(0));
      chk("rst_rsp_data", 32'(o_rsp_data), 32'(0));
      chk("rst_done", 32'(o_done), 32'(0));
      chk("rst_mem_we", 32'(o_mem_we), 32'(0));
      chk("rst_mem_addr", 32'(o_mem_addr), 32'(0));
      m_mode = 0;
      m_rsp_valid = 1'b0;
      m_done = 1'b0;
    end else begin
      chk("busy", 32'(o_busy), 32'(m_mode != 0));
      chk("req_ready", 32'(o_req_ready), 32'(m_mode == 0));
      chk("wdata_ready", 32'(o_wdata_ready), 32'(m_mode == 1));
      chk("done", 32'(o_done), 32'(m_done));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(m_rsp_valid));
      chk("mem_we", 32'(o_mem_we), 32'(m_mode == 1 && i_wdata_valid));
      if (m_mode != 0) chk("mem_addr", 32'(o_mem_addr), 32'(m_addr));
      if (m_rsp_valid) chk("rsp_data", 32'(o_rsp_data), 32'(ref_mem[m_addr]));
      if (o_mem_we) chk("mem_wdata", 32'(o_mem_wdata), 32'(i_wdata));
      if (o_done) done_cnt++;
      if (o_mem_we) we_cnt++;
      m_done = 1'b0;
      case (m_mode)
        0: begin
          if (i_req_valid) begin
            m_mode = i_req_write ? 1 : 2;
            m_addr = i_req_addr;
            m_rem  = int'(i_req_len) + 1;
            m_rsp_valid = 1'b0;
          end
        end
        1: begin
          if (i_wdata_valid) begin
            ref_mem[m_addr] = i_wdata;
            m_finish_beat();
          end
        end
        default: begin
          if (!m_rsp_valid) begin
            m_rsp_valid = 1'b1;
          end else if (i_rsp_ready) begin
            m_rsp_valid = 1'b0;
            m_finish_beat();
          end
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] rd_got[$];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_req(input logic w, input logic [15:0] a, input logic [3:0] l);
    bit ok = 1'b0;
    i_req_valid = 1'b1;
    i_req_write = w;
    i_req_addr  = a;
    i_req_len   = l;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge i_clk);
      if (o_req_ready) ok = 1'b1;
      @(posedge i_clk);
      #1;
    end
    i_req_valid = 1'b0;
    if (!ok) timeout_fail("send_req");
  endtask

  task automatic wr_beat(input logic [15:0] d);
    bit ok = 1'b0;
    i_wdata_valid = 1'b1;
    i_wdata = d;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge i_clk);
      if (o_wdata_ready) ok = 1'b1;
      @(posedge i_clk);
      #1;
    end
    i_wdata_valid = 1'b0;
    if (!ok) timeout_fail("wr_beat");
  endtask

  // Collect n read beats; beat stall_idx is left waiting 5 cycles first.
  task automatic rd_take(input int n, input int stall_idx);
    logic [15:0] held_d;
    logic [15:0] held_a;
    rd_got.delete();
    for (int i = 0; i < n; i++) begin
      bit ok = 1'b0;
      i_rsp_ready = (i != stall_idx);
      for (int k = 0; k < 100 && !ok; k++) begin
        @(negedge i_clk);
        if (o_rsp_valid) ok = 1'b1;
        else begin
          @(posedge i_clk);
          #1;
        end
      end
      if (!ok) begin
        timeout_fail("rd_take");
        i_rsp_ready = 1'b1;
        return;
      end
      rd_got.push_back(o_rsp_data);
      held_d = o_rsp_data;
      held_a = o_mem_addr;
      if (i == stall_idx) begin
        repeat (5) begin
          @(posedge i_clk);
          #1;
          chk("hold_rsp_valid", 32'(o_rsp_valid), 32'(1));
          chk("hold_rsp_data", 32'(o_rsp_data), 32'(held_d));
          chk("hold_mem_addr", 32'(o_mem_addr), 32'(held_a));
        end
        i_rsp_ready = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    i_rsp_ready = 1'b1;
  endtask

  task automatic chk_got(input string nm, input int idx, input logic [15:0] exp);
    if (idx < rd_got.size()) chk(nm, 32'(rd_got[idx]), 32'(exp));
    else timeout_fail(nm);
  endtask

  // ---------------- directed scenarios ----------------
  int d0;
  int w0;

  initial begin
    #1 i_rst = 1'b1;
    idle(3);
    i_rst = 1'b0;
    chk("post_rst_busy", 32'(o_busy), 32'(0));
    chk("post_rst_req_ready", 32'(o_req_ready), 32'(1));

    // 1: single write then single read of the same word
    d0 = done_cnt;
    send_req(1'b1, 16'h0010, 4'd0);
    wr_beat(16'hBEEF);
    i_rsp_ready = 1'b0;
    send_req(1'b0, 16'h0010, 4'd0);
    chk("t1_lat_accept", 32'(o_rsp_valid), 32'(0));
    idle(1);
    chk("t1_lat_next", 32'(o_rsp_valid), 32'(1));
    rd_take(1, -1);
    chk_got("t1_rdata", 0, 16'hBEEF);
    idle(1);
    chk("t1_done_count", 32'(done_cnt - d0), 32'(2));
    chk("t1_mem", 32'(mem[16'h0010]), 32'(16'hBEEF));

    // 2: write burst wrapping through the top of the address space
    d0 = done_cnt;
    send_req(1'b1, 16'hFFFE, 4'd3);
    wr_beat(16'd1);
    wr_beat(16'd2);
    wr_beat(16'd3);
    wr_beat(16'd4);
    idle(1);
    chk("t2_mem_fffe", 32'(mem[16'hFFFE]), 32'(16'd1));
    chk("t2_mem_ffff", 32'(mem[16'hFFFF]), 32'(16'd2));
    chk("t2_mem_0000", 32'(mem[16'h0000]), 32'(16'd3));
    chk("t2_mem_0001", 32'(mem[16'h0001]), 32'(16'd4));
    chk("t2_done_count", 32'(done_cnt - d0), 32'(1));

    // 3: read burst with backpressure on the third beat
    d0 = done_cnt;
    send_req(1'b0, 16'hFFFE, 4'd3);
    rd_take(4, 2);
    chk("t3_beats", 32'(rd_got.size()), 32'(4));
    chk_got("t3_beat0", 0, 16'd1);
    chk_got("t3_beat1", 1, 16'd2);
    chk_got("t3_beat2", 2, 16'd3);
    chk_got("t3_beat3", 3, 16'd4);
    idle(1);
    chk("t3_done_count", 32'(done_cnt - d0), 32'(1));

    // 4: write burst with gaps in the write data stream
    w0 = we_cnt;
    send_req(1'b1, 16'h0400, 4'd2);
    wr_beat(16'hAAA1);
    idle(2);
    wr_beat(16'hAAA2);
    idle(1);
    wr_beat(16'hAAA3);
    idle(1);
    chk("t4_we_count", 32'(we_cnt - w0), 32'(3));
    chk("t4_mem_400", 32'(mem[16'h0400]), 32'(16'hAAA1));
    chk("t4_mem_401", 32'(mem[16'h0401]), 32'(16'hAAA2));
    chk("t4_mem_402", 32'(mem[16'h0402]), 32'(16'hAAA3));
    chk("t4_mem_403", 32'(mem[16'h0403]), 32'(16'hA1A6));

    // 5: request held while busy is taken in the done cycle, intact
    send_req(1'b1, 16'h0200, 4'd1);
    i_req_valid = 1'b1;
    i_req_write = 1'b0;
    i_req_addr  = 16'h0200;
    i_req_len   = 4'd1;
    wr_beat(16'h1111);
    chk("t5_ready_mid", 32'(o_req_ready), 32'(0));
    wr_beat(16'h2222);
    chk("t5_done_pulse", 32'(o_done), 32'(1));
    chk("t5_ready_at_done", 32'(o_req_ready), 32'(1));
    idle(1);
    i_req_valid = 1'b0;
    chk("t5_busy_after", 32'(o_busy), 32'(1));
    chk("t5_done_cleared", 32'(o_done), 32'(0));
    rd_take(2, -1);
    chk_got("t5_beat0", 0, 16'h1111);
    chk_got("t5_beat1", 1, 16'h2222);

    // 6: reset in the middle of a write burst
    w0 = we_cnt;
    send_req(1'b1, 16'h0300, 4'd3);
    wr_beat(16'h7777);
    wr_beat(16'h8888);
    i_wdata_valid = 1'b1;
    i_wdata = 16'h9999;
    i_rst = 1'b1;
    #1;
    chk("t6_we_immediate", 32'(o_mem_we), 32'(0));
    chk("t6_busy_immediate", 32'(o_busy), 32'(0));
    chk("t6_addr_immediate", 32'(o_mem_addr), 32'(0));
    idle(2);
    i_rst = 1'b0;
    i_wdata_valid = 1'b0;
    chk("t6_release_ready", 32'(o_req_ready), 32'(1));
    idle(1);
    chk("t6_we_count", 32'(we_cnt - w0), 32'(2));
    chk("t6_mem_300", 32'(mem[16'h0300]), 32'(16'h7777));
    chk("t6_mem_301", 32'(mem[16'h0301]), 32'(16'h8888));
    chk("t6_mem_302", 32'(mem[16'h0302]), 32'(16'hA6A7));
    chk("t6_mem_303", 32'(mem[16'h0303]), 32'(16'hA6A6));
    send_req(1'b0, 16'h0300, 4'd1);
    rd_take(2, -1);
    chk_got("t6_beat0", 0, 16'h7777);
    chk_got("t6_beat1", 1, 16'h8888);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
